// File: rtl/hls_run_controller.sv
// hls_run_controller: loads a byte stream into a Bambu accelerator's slave memory, runs it, times it, and streams back a result window.
module hls_run_controller #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16,
  parameter int LD_BASE = 0,
  parameter int RD_BASE = 0,
  parameter int RD_LEN = 64,
  parameter int CYC_W = 32,
  parameter int MAX_CYCLES = 200000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic [1:0]            S_oe_ram,
  output logic [1:0]            S_we_ram,
  output logic [2*ADDR_W-1:0]   S_addr_ram,
  output logic [2*DATA_W-1:0]   S_Wdata_ram,
  output logic [7:0]            S_data_ram_size,
  input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
  input  logic [1:0]            Sout_DataRdy,
  output logic                  start_port,
  input  logic                  done_port,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic [CYC_W-1:0]      cycles,
  output logic                  status_valid,
  output logic                  timeout
);
  typedef enum logic [3:0] {IDLE, LOAD, WWAIT, START, RUN, RD_REQ, RD_WAIT, RD_OUT, REPORT} state_t;
  localparam logic [ADDR_W-1:0] LD_B = ADDR_W'(LD_BASE);
  localparam logic [ADDR_W-1:0] RD_B = ADDR_W'(RD_BASE);
  localparam logic [ADDR_W:0] RLEN = (ADDR_W+1)'(RD_LEN);
  localparam logic [CYC_W-1:0] MAX_C = CYC_W'(MAX_CYCLES);
  state_t state, state_nxt;
  logic [ADDR_W-1:0] idx, addr;
  logic [ADDR_W:0] ridx;
  logic [7:0] wdata, rdata;
  logic [CYC_W-1:0] cyc_inc;
  logic last_r, rdy, in_fire, out_fire, run_to, wr_ph, rd_ph;
  logic unused;
  assign unused = &{1'b0, Sout_Rdata_ram[2*DATA_W-1:8], Sout_DataRdy[1]};
  assign rdy = Sout_DataRdy[0];
  // The write-complete cycle doubles as an accept window so streaming loads skip IDLE
  assign in_ready = reset && (state == IDLE || (state == WWAIT && rdy && !last_r));
  assign in_fire = in_valid && in_ready;
  assign out_valid = state == RD_OUT;
  assign out_fire = out_valid && out_ready;
  assign out_data = out_valid ? rdata : 8'd0;
  assign start_port = state == START;
  assign status_valid = state == REPORT;
  assign cyc_inc = &cycles ? cycles : cycles + 1'b1;
  assign run_to = cyc_inc > MAX_C;
  assign wr_ph = state == LOAD || state == WWAIT;
  assign rd_ph = state == RD_REQ || state == RD_WAIT;
  assign addr = rd_ph ? RD_B + ridx[ADDR_W-1:0] : LD_B + idx;
  assign S_we_ram = {1'b0, state == LOAD};
  assign S_oe_ram = {1'b0, state == RD_REQ};
  assign S_addr_ram = (wr_ph || rd_ph) ? {{ADDR_W{1'b0}}, addr} : '0;
  assign S_Wdata_ram = wr_ph ? {{(2*DATA_W-8){1'b0}}, wdata} : '0;
  assign S_data_ram_size = (wr_ph || rd_ph) ? 8'd8 : 8'd0;
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = in_fire ? LOAD : IDLE;
      LOAD:    state_nxt = WWAIT;
      WWAIT:   state_nxt = !rdy ? WWAIT : last_r ? START : in_fire ? LOAD : IDLE;
      START:   state_nxt = RUN;
      RUN:     state_nxt = done_port ? (RLEN == '0 ? REPORT : RD_REQ) : run_to ? REPORT : RUN;
      RD_REQ:  state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = rdy ? RD_OUT : RD_WAIT;
      RD_OUT:  state_nxt = !out_fire ? RD_OUT : (ridx + 1'b1 == RLEN) ? REPORT : RD_REQ;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      idx <= '0;
      ridx <= '0;
      wdata <= '0;
      rdata <= '0;
      last_r <= 1'b0;
      cycles <= '0;
      timeout <= 1'b0;
    end else begin
      if (in_fire) begin
        wdata <= in_data;
        last_r <= in_last;
        cycles <= '0;
        timeout <= 1'b0;
      end
      if (state == WWAIT && rdy) idx <= idx + 1'b1;
      if (state == START) cycles <= CYC_W'(1);
      if (state == RUN) cycles <= cyc_inc;
      // done_port takes priority over a timeout in the same cycle
      if (state == RUN && !done_port && run_to) timeout <= 1'b1;
      if (state == RD_WAIT && rdy) rdata <= Sout_Rdata_ram[7:0];
      if (out_fire) ridx <= ridx + 1'b1;
      if (state == REPORT) begin
        idx <= '0;
        ridx <= '0;
      end
    end
endmodule

// File: tb/tb_hls_run_controller.sv
// tb_hls_run_controller: randomized load/run/readback runs against a slave memory model and arithmetic expectations.
module tb_hls_run_controller;
  localparam int AW = 14, DW = 16, LDB = 16, RDB = 32, RL = 3, MAXC = 8;
  logic clock = 0, reset = 0;
  logic in_valid, in_ready, in_last, start_port, done_port, out_valid, out_ready, status_valid, timeout;
  logic [7:0] in_data, out_data, S_data_ram_size;
  logic [1:0] S_oe_ram, S_we_ram, Sout_DataRdy;
  logic [2*AW-1:0] S_addr_ram;
  logic [2*DW-1:0] S_Wdata_ram, Sout_Rdata_ram;
  logic [31:0] cycles;
  int n_tests, n_fail, start_cnt, stat_cnt, lat_fix;
  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] ref_mem [0:(1<<AW)-1];
  logic [7:0] ld_q [$];
  logic [67:0] we_q [$];
  logic [35:0] oe_q [$];

  hls_run_controller #(.ADDR_W(AW), .DATA_W(DW), .LD_BASE(LDB), .RD_BASE(RDB), .RD_LEN(RL),
                       .CYC_W(32), .MAX_CYCLES(MAXC)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size), .Sout_Rdata_ram(Sout_Rdata_ram),
    .Sout_DataRdy(Sout_DataRdy), .start_port(start_port), .done_port(done_port),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .cycles(cycles),
    .status_valid(status_valid), .timeout(timeout));

  always #5 clock = ~clock;

  // slave memory: answers each we/oe pulse with a one-cycle DataRdy after a latency
  initial begin
    logic [AW-1:0] a;
    logic [7:0] rd;
    Sout_DataRdy = '0;
    Sout_Rdata_ram = '0;
    forever begin
      @(posedge clock);
      #1;
      while (S_we_ram[0] || S_oe_ram[0]) begin
        a = S_addr_ram[AW-1:0];
        if (S_we_ram[0]) mem[a] = S_Wdata_ram[7:0];
        rd = mem[a];
        repeat (lat_fix != 0 ? lat_fix : $urandom_range(1, 3)) @(posedge clock);
        #1;
        Sout_DataRdy = {1'($urandom), 1'b1};
        Sout_Rdata_ram = {16'($urandom), 8'($urandom), rd};
        @(posedge clock);
        #1;
        Sout_DataRdy = '0;
        Sout_Rdata_ram = '0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (S_we_ram[0] || S_oe_ram[0]) begin
        n_tests++;
        if (S_we_ram[0] && S_oe_ram[0]) begin
          n_fail++;
          $display("FAIL oe_we_overlap got oe=%b we=%b want not both", S_oe_ram, S_we_ram);
        end
      end
      if (S_we_ram[0]) we_q.push_back({S_data_ram_size, S_addr_ram, S_Wdata_ram});
      if (S_oe_ram[0]) oe_q.push_back({S_data_ram_size, S_addr_ram});
      if (start_port) start_cnt++;
      if (status_valid) stat_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic load_bytes(input bit noise);
    int guard;
    if (noise) done_port = 1;
    for (int i = 0; i < ld_q.size(); i++) begin
      ref_mem[14'(LDB + i)] = ld_q[i];
      repeat ($urandom_range(0, 2)) @(negedge clock);
      in_valid = 1;
      in_data = ld_q[i];
      in_last = (i == ld_q.size() - 1);
      guard = 0;
      while (!in_ready && guard < 50) begin
        @(negedge clock);
        guard++;
      end
      n_tests++;
      if (guard >= 50) begin
        n_fail++;
        $display("FAIL load_accept byte %0d got in_ready=0 for 50 cycles want accept", i);
      end
      @(posedge clock);
      #1;
      in_valid = 0;
      in_last = 0;
      @(negedge clock);
    end
    done_port = 0;
  endtask

  task automatic run_scenario(input string name, input int d, input bit det, input bit noise);
    int n, d_eff, exp_cyc, nexp, k, t, stall, guard;
    bit exp_to, started;
    logic [7:0] exp_b;
    n = ld_q.size();
    we_q.delete();
    oe_q.delete();
    start_cnt = 0;
    stat_cnt = 0;
    load_bytes(noise);
    d_eff = d < 1 ? 1 : d;
    exp_to = d_eff > MAXC;
    exp_cyc = exp_to ? MAXC + 1 : d_eff + 1;
    nexp = exp_to ? 0 : RL;
    started = 0; t = 0; k = 0; stall = 0; guard = 0;
    while (!status_valid && guard < 300) begin
      if (started) t++;
      if (start_port) started = 1;
      if (started && t == d) done_port = 1;
      if (out_valid) begin
        out_ready = det ? !(k == 1 && stall < 3) : 1'($urandom);
        if (det && k == 1 && !out_ready) stall++;
        exp_b = ref_mem[14'(RDB + k)];
        n_tests++;
        if (k >= nexp || out_data !== exp_b) begin
          n_fail++;
          $display("FAIL %s out_byte[%0d] got %h want %h (expected %0d bytes)", name, k, out_data, exp_b, nexp);
        end
        if (out_ready) k++;
      end else out_ready = 1'($urandom);
      @(negedge clock);
      guard++;
    end
    done_port = 0;
    out_ready = 0;
    n_tests++;
    if (guard >= 300) begin
      n_fail++;
      $display("FAIL %s report_wait got no status_valid in 300 cycles want report", name);
    end
    n_tests++;
    if (cycles !== 32'(exp_cyc) || timeout !== exp_to) begin
      n_fail++;
      $display("FAIL %s status got cycles=%0d timeout=%b want cycles=%0d timeout=%b", name, cycles, timeout, exp_cyc, exp_to);
    end
    n_tests++;
    if (k != nexp || start_cnt != 1) begin
      n_fail++;
      $display("FAIL %s counts got bytes=%0d starts=%0d want bytes=%0d starts=1", name, k, start_cnt, nexp);
    end
    n_tests++;
    if (we_q.size() != n || oe_q.size() != nexp) begin
      n_fail++;
      $display("FAIL %s pulses got we=%0d oe=%0d want we=%0d oe=%0d", name, we_q.size(), oe_q.size(), n, nexp);
    end
    for (int i = 0; i < n && i < we_q.size(); i++) begin
      n_tests++;
      if (we_q[i] !== {8'd8, 14'd0, 14'(LDB + i), 24'd0, ld_q[i]}) begin
        n_fail++;
        $display("FAIL %s write[%0d] got %h want %h", name, i, we_q[i], {8'd8, 14'd0, 14'(LDB + i), 24'd0, ld_q[i]});
      end
    end
    for (int i = 0; i < nexp && i < oe_q.size(); i++) begin
      n_tests++;
      if (oe_q[i] !== {8'd8, 14'd0, 14'(RDB + i)}) begin
        n_fail++;
        $display("FAIL %s read_req[%0d] got %h want %h", name, i, oe_q[i], {8'd8, 14'd0, 14'(RDB + i)});
      end
    end
    @(negedge clock);
    n_tests++;
    if (status_valid !== 0 || stat_cnt != 1 || in_ready !== 1 || cycles !== 32'(exp_cyc) || timeout !== exp_to) begin
      n_fail++;
      $display("FAIL %s after_report got sv=%b pulses=%0d in_ready=%b cycles=%0d timeout=%b want 0 1 1 %0d %b",
               name, status_valid, stat_cnt, in_ready, cycles, timeout, exp_cyc, exp_to);
    end
  endtask

  task automatic test_reset;
    reset = 0;
    repeat (3) @(negedge clock);
    n_tests++;
    if ({S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size, start_port, out_valid, out_data,
         cycles, status_valid, timeout, in_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got oe=%b we=%b addr=%h cyc=%0d sv=%b to=%b rdy=%b want all 0",
               S_oe_ram, S_we_ram, S_addr_ram, cycles, status_valid, timeout, in_ready);
    end
    reset = 1;
    @(negedge clock);
    n_tests++;
    if (in_ready !== 1 || S_we_ram !== 0 || start_port !== 0) begin
      n_fail++;
      $display("FAIL reset_idle got in_ready=%b we=%b start=%b want 1 0 0", in_ready, S_we_ram, start_port);
    end
  endtask

  task automatic test_basic_run;
    ld_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < RL; i++) begin
      mem[14'(RDB + i)] = 8'hA0 + 8'(i);
      ref_mem[14'(RDB + i)] = 8'hA0 + 8'(i);
    end
    lat_fix = 2;
    run_scenario("basic", 7, 1, 0);
  endtask

  task automatic test_timeout;
    ld_q = '{8'($urandom), 8'($urandom)};
    lat_fix = 0;
    run_scenario("timeout", 1000, 0, 0);
  endtask

  task automatic test_coincident;
    ld_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
    run_scenario("coincident", MAXC, 0, 0);
  endtask

  task automatic test_done_at_start;
    ld_q = '{8'($urandom), 8'($urandom)};
    run_scenario("done_at_start", 0, 0, 1);
  endtask

  task automatic test_random_runs;
    for (int r = 0; r < 8; r++) begin
      ld_q.delete();
      repeat ($urandom_range(1, 24)) ld_q.push_back(8'($urandom));
      lat_fix = $urandom_range(0, 3);
      run_scenario("random", $urandom_range(0, MAXC + 3), 0, 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_run;
    int t, guard;
    bit started;
    ld_q = '{8'($urandom)};
    we_q.delete();
    load_bytes(0);
    started = 0; t = 0; guard = 0;
    while (guard < 100) begin
      if (started) t++;
      if (start_port) started = 1;
      if (started && t == 3) break;
      @(negedge clock);
      guard++;
    end
    n_tests++;
    if (cycles !== 32'd3) begin
      n_fail++;
      $display("FAIL mid_run_cycles got %0d want 3", cycles);
    end
    reset = 0;
    #1;
    n_tests++;
    if ({S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size, start_port, out_valid, out_data,
         cycles, status_valid, timeout, in_ready} !== '0) begin
      n_fail++;
      $display("FAIL mid_run_reset got start=%b cyc=%0d sv=%b rdy=%b want all 0", start_port, cycles, status_valid, in_ready);
    end
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    ld_q = '{8'($urandom)};
    run_scenario("after_reset", 4, 0, 0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; lat_fix = 0;
    in_valid = 0; in_data = 0; in_last = 0; done_port = 0; out_ready = 0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset;
    test_basic_run;
    test_timeout;
    test_coincident;
    test_done_at_start;
    test_random_runs;
    test_reset_mid_run;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
